sdp_be_march_bist: RTL
======================

// Module: sdp_be_march_bist
// PURPOSE
// - Built-in self-test initiator for the simple-dual-port byte-enable BRAM interface (we/be/wa/wd write port, ra/rd read port).
// - Drives the write and read ports of one SDP_be RAM instance with a March C- sequence, then a byte-enable masking phase.
// - Compares read data per byte lane and reports pass/fail, first-failure location and an error count.
// - Sits beside a mapped BRAM on silicon/FPGA bring-up designs and in simulation against behavioural RAM models.
// PARAMETERS
// - ABITS      4  address width, shared by read and write ports; N = 2**ABITS words
// - NBYTES     2  number of byte lanes
// - BYTEWIDTH  8  bits per lane; DBITS = NBYTES*BYTEWIDTH (derived localparam)
// - CNTBITS   16  width of err_count
// PORTS
// - clk         in   1          single clock; all logic on posedge
// - rst         in   1          asynchronous, active-high reset
// - start       in   1          begin test; sampled only in IDLE or DONE
// - busy        out  1          test in progress
// - done        out  1          test finished; held until next accepted start
// - pass        out  1          valid while done; 1 = zero mismatches
// - fail_addr   out  ABITS      address of first mismatch
// - fail_lanes  out  NBYTES     per-lane mismatch mask of first mismatch
// - fail_phase  out  3          phase code of first mismatch (pkg enum)
// - err_count   out  CNTBITS    mismatching compares, saturating at all-ones
// - ram_we      out  1          RAM write enable
// - ram_be      out  NBYTES     RAM byte enables
// - ram_wa      out  ABITS      RAM write address
// - ram_wd      out  DBITS      RAM write data
// - ram_ra      out  ABITS      RAM read address
// - ram_rd      in   DBITS      RAM read data, registered, valid 1 cycle after ram_ra
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE. Reset mid-test aborts immediately: ram_we=0 while rst high; no partial status kept.
// - start accepted in IDLE/DONE: clears done/pass/fail_*/err_count; next cycle busy=1, first op issued. start while busy ignored.
// - Phases (0=all-zero word, 1=all-ones word, ram_be all-ones unless stated):
//   W0_UP    addr 0..N-1: 1 write/cycle, wd=0                          (N cycles)
//   R0W1_UP  per addr: cyc A ra=addr; cyc B compare rd==0, write 1      (2N)
//   R1W0_UP  as above, expect 1, write 0                               (2N)
//   R0W1_DN  addr N-1..0, expect 0, write 1                             (2N)
//   R1W0_DN  addr N-1..0, expect 1, write 0                             (2N)
//   R0_UP    1 read/cycle, compare pipelined 1 cycle behind, +1 drain   (N+1)
//   BE_UP    per addr: c1 write 1 be=all; c2 write 0 be=even lanes only;
//            c3 ra=addr; c4 compare: even lanes 0, odd lanes all-ones   (4N)
// - Total busy = 14N+1 cycles; done rises and busy falls the cycle after the last compare.
// - Read and write to the same address never issued in the same cycle (no collision reliance).
// - Descending address counter wraps N-1..0 with no skip; ascending stops at N-1, no modulo overrun.
// - Compare: lane i mismatches if rd lane i != expected lane i. Any lane set -> err_count+1 (saturate).
// - First mismatch only latches fail_addr/fail_lanes/fail_phase; later mismatches count only.
// - pass = (err_count==0) registered at done; pass=0 whenever done=0.
// - ram_we=0 in IDLE/DONE and on all read-only cycles; ram_ra/ram_wa hold last value when unused.
// STRUCTURE
// - Package sdp_be_bist_pkg: phase enum (3-bit, W0_UP=0 .. BE_UP=6, IDLE/DONE states), even-lane mask function, all-0/all-1 pattern functions.
// - Sub-module sdp_be_lane_cmp: combinational per-lane compare of rd vs expected -> NBYTES mismatch mask.
// - Top: phase FSM, address counter (up/down), 2-bit sub-step counter, status/error registers.
// TESTING (bench: behavioural SDP_be RAM, registered read, ABITS=4, NBYTES=2, BYTEWIDTH=8)
// - Clean RAM, pulse start -> busy high exactly 225 cycles; done=1, pass=1, err_count=0.
// - Bit 3 of addr 5 stuck at 1 -> fail_phase=R0W1_UP, fail_addr=5, fail_lanes=2'b01, pass=0, err_count>=1.
// - RAM ignores be (writes all lanes) -> only BE_UP fails: fail_addr=0, fail_lanes=2'b10, err_count=16.
// - rst pulsed during R1W0_DN -> all outputs 0 at once, ram_we=0; new start -> full pass in 225 cycles.
// - start pulsed while busy -> ignored, timing unchanged; start in DONE -> status cleared, rerun passes.
// - Monitor ram_ra in R0W1_DN: addresses 15,14,..,0 in order, one per 2 cycles, no write in read cycles.

Source files
------------

// File: rtl/sdp_be_march_bist_pkg.sv
// Shared types and pattern helpers for the SDP byte-enable March C- BIST.
// Phase codes double as the fail_phase encoding reported to software.
package sdp_be_bist_pkg;

  typedef enum logic [2:0] {
    PH_W0_UP   = 3'd0,
    PH_R0W1_UP = 3'd1,
    PH_R1W0_UP = 3'd2,
    PH_R0W1_DN = 3'd3,
    PH_R1W0_DN = 3'd4,
    PH_R0_UP   = 3'd5,
    PH_BE_UP   = 3'd6
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MAX_LANES = 32;
  localparam int MAX_DBITS = 256;

  function automatic logic [MAX_LANES-1:0] even_lane_mask();
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [MAX_DBITS-1:0] pat_word(input logic one);
    return one ? {MAX_DBITS{1'b1}} : {MAX_DBITS{1'b0}};
  endfunction

  // Expands a lane mask into a data word with every bit of a selected lane set.
  function automatic logic [MAX_DBITS-1:0] lanes_to_word(input logic [MAX_LANES-1:0] lanes,
                                                         input int bw);
    logic [MAX_DBITS-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_DBITS; i++) begin
      if (((i / bw) < MAX_LANES) && lanes[i / bw]) w[i] = 1'b1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sdp_be_march_bist_if.sv
// RAM-side bus between the BIST initiator (master) and one SDP_be RAM (slave).
interface sdp_be_march_bist_if #(
  parameter int ABITS     = 4,
  parameter int NBYTES    = 2,
  parameter int BYTEWIDTH = 8
);
  localparam int DBITS = NBYTES * BYTEWIDTH;

  // No handshake: ram_we qualifies a write in the cycle it is high; reads are
  // unconditional and ram_rd reflects ram_ra from the previous cycle.
  logic              ram_we;
  logic [NBYTES-1:0] ram_be;
  logic [ABITS-1:0]  ram_wa;
  logic [DBITS-1:0]  ram_wd;
  logic [ABITS-1:0]  ram_ra;
  logic [DBITS-1:0]  ram_rd;

  modport master (output ram_we, ram_be, ram_wa, ram_wd, ram_ra, input ram_rd);
  modport slave  (input ram_we, ram_be, ram_wa, ram_wd, ram_ra, output ram_rd);

endinterface

// File: rtl/sdp_be_lane_cmp.sv
// Combinational per-lane compare of read data against the expected word.
module sdp_be_lane_cmp #(
  parameter int NBYTES    = 2,
  parameter int BYTEWIDTH = 8
) (
  input  logic [NBYTES*BYTEWIDTH-1:0] rd,
  input  logic [NBYTES*BYTEWIDTH-1:0] exp_word,
  output logic [NBYTES-1:0]           mism
);

  always_comb begin
    mism = '0;
    for (int i = 0; i < NBYTES; i++) begin
      mism[i] = (rd[i*BYTEWIDTH +: BYTEWIDTH] != exp_word[i*BYTEWIDTH +: BYTEWIDTH]);
    end
  end

endmodule

// File: rtl/sdp_be_march_bist.sv
// March C- plus byte-enable masking BIST for one SDP_be RAM.
// Reads are tagged into a one-deep pending-compare stage checked when ram_rd returns.
module sdp_be_march_bist
  import sdp_be_bist_pkg::*;
#(
  parameter int ABITS     = 4,
  parameter int NBYTES    = 2,
  parameter int BYTEWIDTH = 8,
  parameter int CNTBITS   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ABITS-1:0]    fail_addr,
  output logic [NBYTES-1:0]   fail_lanes,
  output phase_e              fail_phase,
  output logic [CNTBITS-1:0]  err_count,
  output state_e              dbg_state,
  output phase_e              dbg_phase,
  sdp_be_march_bist_if.master ram
);

  localparam int DBITS = NBYTES * BYTEWIDTH;
  localparam logic [ABITS-1:0]     ADDR_LAST = '1;
  localparam logic [CNTBITS-1:0]   ERR_MAX   = '1;
  localparam logic [NBYTES-1:0]    BE_ALL    = '1;
  localparam logic [MAX_DBITS-1:0] ONES_FULL = pat_word(1'b1);
  localparam logic [MAX_DBITS-1:0] ZERO_FULL = pat_word(1'b0);
  localparam logic [MAX_LANES-1:0] EVEN_FULL = even_lane_mask();
  localparam logic [MAX_DBITS-1:0] ODD_FULL  = lanes_to_word(~EVEN_FULL, BYTEWIDTH);
  localparam logic [DBITS-1:0]     WORD_1    = ONES_FULL[DBITS-1:0];
  localparam logic [DBITS-1:0]     WORD_0    = ZERO_FULL[DBITS-1:0];
  localparam logic [DBITS-1:0]     WORD_BE   = ODD_FULL[DBITS-1:0];
  localparam logic [NBYTES-1:0]    BE_EVEN   = EVEN_FULL[NBYTES-1:0];

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d, pphase_q, pphase_d, fphase_q, fphase_d;
  logic [ABITS-1:0]    addr_q, addr_d, paddr_q, paddr_d, faddr_q, faddr_d;
  logic [ABITS-1:0]    wa_q, ra_q, wa_c, ra_c;
  logic [1:0]          step_q, step_d;
  logic                pend_q, pend_d, pass_q, pass_d;
  logic [DBITS-1:0]    pexp_q, pexp_d, wd_c;
  logic [NBYTES-1:0]   flanes_q, flanes_d, be_c, mism;
  logic [CNTBITS-1:0]  err_q, err_d;
  logic                we_c, rw_exp1, rw_down, rw_last;

  sdp_be_lane_cmp #(.NBYTES(NBYTES), .BYTEWIDTH(BYTEWIDTH)) u_lane_cmp (
    .rd       (ram.ram_rd),
    .exp_word (pexp_q),
    .mism     (mism)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    addr_d   = addr_q;
    step_d   = step_q;
    pend_d   = 1'b0;
    pexp_d   = pexp_q;
    paddr_d  = paddr_q;
    pphase_d = pphase_q;
    err_d    = err_q;
    faddr_d  = faddr_q;
    flanes_d = flanes_q;
    fphase_d = fphase_q;
    pass_d   = pass_q;
    we_c     = 1'b0;
    be_c     = '0;
    wd_c     = '0;
    wa_c     = wa_q;
    ra_c     = ra_q;
    rw_exp1  = (phase_q == PH_R1W0_UP) || (phase_q == PH_R1W0_DN);
    rw_down  = (phase_q == PH_R0W1_DN) || (phase_q == PH_R1W0_DN);
    rw_last  = rw_down ? (addr_q == '0) : (addr_q == ADDR_LAST);

    // Compare stage: only the first mismatch is located, later ones just count.
    if (pend_q && (mism != '0)) begin
      if (err_q == '0) begin
        faddr_d  = paddr_q;
        flanes_d = mism;
        fphase_d = pphase_q;
      end
      if (err_q != ERR_MAX) err_d = err_q + CNTBITS'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          phase_d  = PH_W0_UP;
          addr_d   = '0;
          step_d   = 2'd0;
          err_d    = '0;
          faddr_d  = '0;
          flanes_d = '0;
          fphase_d = PH_W0_UP;
          pass_d   = 1'b0;
        end
      end
      ST_RUN: begin
        case (phase_q)
          PH_W0_UP: begin
            we_c = 1'b1;
            be_c = BE_ALL;
            wa_c = addr_q;
            wd_c = WORD_0;
            if (addr_q == ADDR_LAST) begin
              phase_d = PH_R0W1_UP;
              addr_d  = '0;
            end else begin
              addr_d = addr_q + ABITS'(1);
            end
          end
          PH_R0W1_UP, PH_R1W0_UP, PH_R0W1_DN, PH_R1W0_DN: begin
            if (step_q == 2'd0) begin
              ra_c     = addr_q;
              pend_d   = 1'b1;
              pexp_d   = rw_exp1 ? WORD_1 : WORD_0;
              paddr_d  = addr_q;
              pphase_d = phase_q;
              step_d   = 2'd1;
            end else begin
              we_c   = 1'b1;
              be_c   = BE_ALL;
              wa_c   = addr_q;
              wd_c   = rw_exp1 ? WORD_0 : WORD_1;
              step_d = 2'd0;
              if (rw_last) begin
                case (phase_q)
                  PH_R0W1_UP: begin phase_d = PH_R1W0_UP; addr_d = '0;        end
                  PH_R1W0_UP: begin phase_d = PH_R0W1_DN; addr_d = ADDR_LAST; end
                  PH_R0W1_DN: begin phase_d = PH_R1W0_DN; addr_d = ADDR_LAST; end
                  default:    begin phase_d = PH_R0_UP;   addr_d = '0;        end
                endcase
              end else begin
                addr_d = rw_down ? (addr_q - ABITS'(1)) : (addr_q + ABITS'(1));
              end
            end
          end
          PH_R0_UP: begin
            // step 1 is the drain cycle for the last pipelined compare
            if (step_q == 2'd0) begin
              ra_c     = addr_q;
              pend_d   = 1'b1;
              pexp_d   = WORD_0;
              paddr_d  = addr_q;
              pphase_d = phase_q;
              if (addr_q == ADDR_LAST) step_d = 2'd1;
              else                     addr_d = addr_q + ABITS'(1);
            end else begin
              phase_d = PH_BE_UP;
              addr_d  = '0;
              step_d  = 2'd0;
            end
          end
          PH_BE_UP: begin
            case (step_q)
              2'd0: begin
                we_c   = 1'b1;
                be_c   = BE_ALL;
                wa_c   = addr_q;
                wd_c   = WORD_1;
                step_d = 2'd1;
              end
              2'd1: begin
                we_c   = 1'b1;
                be_c   = BE_EVEN;
                wa_c   = addr_q;
                wd_c   = WORD_0;
                step_d = 2'd2;
              end
              2'd2: begin
                ra_c     = addr_q;
                pend_d   = 1'b1;
                pexp_d   = WORD_BE;
                paddr_d  = addr_q;
                pphase_d = phase_q;
                step_d   = 2'd3;
              end
              default: begin
                step_d = 2'd0;
                if (addr_q == ADDR_LAST) begin
                  state_d = ST_DONE;
                  pass_d  = (err_d == '0);
                end else begin
                  addr_d = addr_q + ABITS'(1);
                end
              end
            endcase
          end
          default: state_d = ST_IDLE;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_W0_UP;
      addr_q   <= '0;
      step_q   <= 2'd0;
      pend_q   <= 1'b0;
      pexp_q   <= '0;
      paddr_q  <= '0;
      pphase_q <= PH_W0_UP;
      err_q    <= '0;
      faddr_q  <= '0;
      flanes_q <= '0;
      fphase_q <= PH_W0_UP;
      pass_q   <= 1'b0;
      wa_q     <= '0;
      ra_q     <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      step_q   <= step_d;
      pend_q   <= pend_d;
      pexp_q   <= pexp_d;
      paddr_q  <= paddr_d;
      pphase_q <= pphase_d;
      err_q    <= err_d;
      faddr_q  <= faddr_d;
      flanes_q <= flanes_d;
      fphase_q <= fphase_d;
      pass_q   <= pass_d;
      wa_q     <= wa_c;
      ra_q     <= ra_c;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign fail_addr  = faddr_q;
  assign fail_lanes = flanes_q;
  assign fail_phase = fphase_q;
  assign err_count  = err_q;
  assign dbg_state  = state_q;
  assign dbg_phase  = phase_q;

  assign ram.ram_we = we_c;
  assign ram.ram_be = be_c;
  assign ram.ram_wa = wa_c;
  assign ram.ram_wd = wd_c;
  assign ram.ram_ra = ra_c;

endmodule
